// File: rtl/ks_note_sequencer.sv
// Step sequencer for the Karplus-Strong voice: walks a small period table at a
// programmable tempo, presenting each step's period and a stretched pluck pulse.
module ks_note_sequencer #(
    parameter int NUM_STEPS    = 8,
    parameter int STEP_AW      = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int TEMPO_WIDTH  = 12,
    parameter int PLUCK_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   run_i,
    input  logic [TEMPO_WIDTH-1:0] tempo_i,
    input  logic [STEP_AW-1:0]     length_i,
    input  logic                   wr_en_i,
    input  logic [STEP_AW-1:0]     wr_addr_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i,
    output logic                   pluck_o,
    output logic [DATA_WIDTH-1:0]  period_o,
    output logic [STEP_AW-1:0]     step_o,
    output logic                   playing_o
);

    localparam int PCW = $clog2(PLUCK_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [TEMPO_WIDTH-1:0]  tick_q, tick_d;
    logic [STEP_AW-1:0]      step_q, step_d, fire_step_s;
    logic [DATA_WIDTH-1:0]   period_q, period_d, entry_s;
    logic [PCW-1:0]          pcnt_q, pcnt_d;
    logic                    pluck_q, pluck_d;
    logic                    playing_q, playing_d;
    logic                    fire_s;
    logic [DATA_WIDTH-1:0]   table_q [NUM_STEPS];
    logic [DATA_WIDTH-1:0]   table_d [NUM_STEPS];

    // Sequencing FSM: tempo tick, step advance, fire handling and pluck counter
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        step_d      = step_q;
        period_d    = period_q;
        fire_s      = 1'b0;
        fire_step_s = '0;
        if (pcnt_q != '0) begin
            pcnt_d = pcnt_q - PCW'(1);
        end else begin
            pcnt_d = '0;
        end

        case (state_q)
            ST_IDLE: begin
                tick_d = '0;
                step_d = '0;
                pcnt_d = '0;
                if (run_i) begin
                    state_d = ST_PLAY;
                    fire_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PLAY: begin
                // stop wins over a fire landing on the same edge
                if (!run_i) begin
                    state_d = ST_IDLE;
                    tick_d  = '0;
                    step_d  = '0;
                    pcnt_d  = '0;
                end else if (tick_q == tempo_i) begin
                    tick_d      = '0;
                    fire_s      = 1'b1;
                    fire_step_s = (step_q >= length_i) ? '0 : step_q + STEP_AW'(1);
                    step_d      = fire_step_s;
                end else begin
                    tick_d = tick_q + TEMPO_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tick_d  = '0;
                step_d  = '0;
                pcnt_d  = '0;
            end
        endcase

        // table_q is the pre-write value, so a coincident write lands next lap
        entry_s = table_q[fire_step_s];
        if (fire_s && (entry_s != '0)) begin
            period_d = entry_s;
            pcnt_d   = PCW'(PLUCK_CYCLES);
        end else begin
            period_d = period_q;
        end

        pluck_d   = (pcnt_d != '0);
        playing_d = (state_d == ST_PLAY);
    end

    // Step table write port
    always_comb begin
        for (int i = 0; i < NUM_STEPS; i++) begin
            table_d[i] = (wr_en_i && (wr_addr_i == STEP_AW'(i))) ? wr_data_i : table_q[i];
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            step_q    <= '0;
            period_q  <= '0;
            pcnt_q    <= '0;
            pluck_q   <= 1'b0;
            playing_q <= 1'b0;
            for (int i = 0; i < NUM_STEPS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            step_q    <= step_d;
            period_q  <= period_d;
            pcnt_q    <= pcnt_d;
            pluck_q   <= pluck_d;
            playing_q <= playing_d;
            for (int i = 0; i < NUM_STEPS; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

    assign pluck_o   = pluck_q;
    assign period_o  = period_q;
    assign step_o    = step_q;
    assign playing_o = playing_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Self-checking bench for ks_note_sequencer: directed scenarios plus random
// traffic, compared every cycle against a fire-time based reference model.
module tb_ks_note_sequencer;

    localparam int NS = 8;
    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TW = 12;
    localparam int PC = 4;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          run_i;
    logic [TW-1:0] tempo_i;
    logic [AW-1:0] length_i;
    logic          wr_en_i;
    logic [AW-1:0] wr_addr_i;
    logic [DW-1:0] wr_data_i;
    logic          pluck_o;
    logic [DW-1:0] period_o;
    logic [AW-1:0] step_o;
    logic          playing_o;

    ks_note_sequencer #(
        .NUM_STEPS(NS), .STEP_AW(AW), .DATA_WIDTH(DW),
        .TEMPO_WIDTH(TW), .PLUCK_CYCLES(PC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .run_i(run_i), .tempo_i(tempo_i),
        .length_i(length_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .pluck_o(pluck_o), .period_o(period_o),
        .step_o(step_o), .playing_o(playing_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: cycle count, time of last fire, and pluck end time
    int       cyc = 0;
    bit       m_play;
    int       m_step;
    int       m_since;
    int       m_period;
    int       m_pluck_end;
    int       m_mem [NS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_play = 1'b0; m_step = 0; m_since = 0; m_period = 0; m_pluck_end = 0;
        for (int i = 0; i < NS; i++) m_mem[i] = 0;
    endtask

    task automatic model_fire(input int s);
        m_step  = s;
        m_since = 0;
        if (m_mem[s] != 0) begin
            m_period    = m_mem[s];
            m_pluck_end = cyc + PC;
        end
    endtask

    task automatic model_edge();
        if (!m_play) begin
            if (run_i) begin
                m_play = 1'b1;
                model_fire(0);
            end
        end else if (!run_i) begin
            m_play = 1'b0; m_step = 0; m_since = 0; m_pluck_end = cyc;
        end else begin
            m_since++;
            if (m_since > int'(tempo_i))
                model_fire((m_step >= int'(length_i)) ? 0 : m_step + 1);
        end
        if (wr_en_i) m_mem[wr_addr_i] = int'(wr_data_i);
    endtask

    task automatic compare_all();
        chk("pluck",   {31'd0, pluck_o},   (cyc < m_pluck_end) ? 32'd1 : 32'd0);
        chk("period",  {24'd0, period_o},  m_period);
        chk("step",    {29'd0, step_o},    m_step);
        chk("playing", {31'd0, playing_o}, {31'd0, m_play});
    endtask

    task automatic tick_cycle();
        @(posedge clk_i);
        cyc++;
        if (rst_ni) model_edge();
        #1;
        compare_all();
    endtask

    task automatic wr(input int a, input int d);
        wr_en_i = 1'b1; wr_addr_i = AW'(a); wr_data_i = DW'(d);
        tick_cycle();
        wr_en_i = 1'b0;
    endtask

    // Asynchronous reset asserted and released mid-cycle
    task automatic async_reset();
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("rst_pluck",   {31'd0, pluck_o}, 32'd0);
        chk("rst_period",  {24'd0, period_o}, 32'd0);
        chk("rst_step",    {29'd0, step_o}, 32'd0);
        chk("rst_playing", {31'd0, playing_o}, 32'd0);
        tick_cycle();
        tick_cycle();
        #2;
        rst_ni = 1'b1;
    endtask

    int n;
    int last_rise;
    logic prev_pluck;
    int old0;

    initial begin
        rst_ni = 1'b1; run_i = 1'b0; tempo_i = '0; length_i = '0;
        wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        model_reset();
        tick_cycle();
        async_reset();

        // Basic playback with pluck spacing check
        wr(0, 10); wr(1, 20); wr(2, 30); wr(3, 40);
        length_i = 3'd3; tempo_i = 12'd9; run_i = 1'b1;
        prev_pluck = 1'b0; last_rise = -1;
        for (int i = 0; i < 45; i++) begin
            tick_cycle();
            if (pluck_o && !prev_pluck) begin
                if (last_rise >= 0) chk("pluck_spacing", cyc - last_rise, 10);
                last_rise = cyc;
            end
            prev_pluck = pluck_o;
        end
        run_i = 1'b0; tick_cycle();

        // Rest on step 1
        wr(1, 0);
        run_i = 1'b1;
        for (int i = 0; i < 45; i++) tick_cycle();
        run_i = 1'b0; tick_cycle();

        // Stretched pulse
        wr(1, 20);
        tempo_i = 12'd1; run_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            chk("stretch", {31'd0, pluck_o}, 32'd1);
        end
        run_i = 1'b0; tick_cycle();

        // Lower length while at step 5
        for (int i = 4; i < NS; i++) wr(i, 50 + i);
        tempo_i = 12'd3; length_i = 3'd7; run_i = 1'b1;
        n = 0;
        while (!(m_play && m_step == 5 && m_since == 1) && n < 200) begin tick_cycle(); n++; end
        chk("wait_step5", {31'd0, n < 200}, 32'd1);
        length_i = 3'd2;
        n = 0;
        do begin tick_cycle(); n++; end while (m_since != 0 && n < 50);
        chk("len_wrap", {29'd0, step_o}, 32'd0);

        // Write step 0 on the same edge as its fire
        n = 0;
        while (!(m_step == 2 && m_since == 3) && n < 100) begin tick_cycle(); n++; end
        chk("wait_pre_fire", {31'd0, n < 100}, 32'd1);
        old0 = m_mem[0];
        wr(0, 99);
        chk("coincident_old", {24'd0, period_o}, old0);
        n = 0;
        do begin tick_cycle(); n++; end while (!(m_step == 0 && m_since == 0) && n < 50);
        chk("coincident_new", {24'd0, period_o}, 32'd99);

        // Stop exactly when tick reaches tempo, then restart
        n = 0;
        while (m_since != 3 && n < 50) begin tick_cycle(); n++; end
        run_i = 1'b0;
        tick_cycle();
        chk("stop_step",    {29'd0, step_o}, 32'd0);
        chk("stop_playing", {31'd0, playing_o}, 32'd0);
        chk("stop_pluck",   {31'd0, pluck_o}, 32'd0);
        tick_cycle();
        run_i = 1'b1;
        tick_cycle();
        chk("restart_pluck", {31'd0, pluck_o}, 32'd1);
        chk("restart_step",  {29'd0, step_o}, 32'd0);
        for (int i = 0; i < 7; i++) tick_cycle();

        // Reset while playing: table becomes rests
        async_reset();
        for (int i = 0; i < 20; i++) begin
            tick_cycle();
            chk("post_rst_rest", {31'd0, pluck_o}, 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            wr_en_i   = ($urandom_range(0, 3) == 0);
            wr_addr_i = AW'($urandom_range(0, NS - 1));
            wr_data_i = ($urandom_range(0, 3) == 0) ? 8'd0 : DW'($urandom_range(1, 255));
            if (!m_play) tempo_i = TW'($urandom_range(0, 6));
            if ($urandom_range(0, 19) == 0) length_i = AW'($urandom_range(0, NS - 1));
            if ($urandom_range(0, 29) == 0) run_i = ~run_i;
            tick_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ks_note_sequencer.md
# ks_note_sequencer

Step sequencer that drives the Karplus-Strong string voice automatically. It holds a small programmable table of string periods and walks it at a programmable tempo. On every step it presents the new period and raises a pluck pulse, so the voice plays a repeating melody without SPI traffic per note. It sits directly upstream of `ks_string`: `period_o` feeds `period_i` and `pluck_o` feeds `pluck_i`, with the top level ORing in the manual pluck. Its step table and controls come from the SPI register map.

## Interface
Parameters:
- `NUM_STEPS`, 8: table depth; power of two.
- `STEP_AW`, 3: step address width; equals log2(`NUM_STEPS`).
- `DATA_WIDTH`, 8: period width; matches the `ks_string` period input.
- `TEMPO_WIDTH`, 12: tempo counter width.
- `PLUCK_CYCLES`, 4: pluck pulse length in `clk_i` cycles; at least 1.

Ports:
- `clk_i`  in  1  sequencer clock; the same clock as `ks_string` (`clk_16`).
- `rst_ni`  in  1  asynchronous, active-low reset.
- `run_i`  in  1  level; high plays the table, low stops and rewinds to step 0.
- `tempo_i`  in  TEMPO_WIDTH  step duration minus 1, in `clk_i` cycles.
- `length_i`  in  STEP_AW  index of the last step (number of steps minus 1).
- `wr_en_i`  in  1  table write strobe, one cycle per write.
- `wr_addr_i`  in  STEP_AW  table write address.
- `wr_data_i`  in  DATA_WIDTH  period to store; 0 marks a rest.
- `pluck_o`  out  1  pluck pulse to the string.
- `period_o`  out  DATA_WIDTH  current string period.
- `step_o`  out  STEP_AW  index of the step currently sounding.
- `playing_o`  out  1  high while in PLAY.

## Operation
- The table is `NUM_STEPS` x `DATA_WIDTH` flops. Async reset clears every entry to 0.
- Writes are accepted in any state: `wr_en_i` stores `wr_data_i` at `wr_addr_i` on the clock edge.
- The state machine has two states, IDLE and PLAY.
- **IDLE:**
  - tick counter = 0, step = 0, `playing_o` = 0, `pluck_o` = 0.
  - `period_o` holds its last value.
  - If `run_i` = 1: go to PLAY and perform a fire of step 0 on the same edge.
- **PLAY:**
  - The tick counter increments every cycle.
  - When tick = `tempo_i`: tick clears to 0 and the next step is fired.
  - Next step = 0 if step >= `length_i`, otherwise step + 1.
  - This also covers `length_i` being lowered below the current step: the sequence wraps to 0.
  - If `run_i` = 0: go to IDLE. Tick and step clear and `pluck_o` drops on that edge. `run_i` has priority over a coincident fire.
- **Fire of step s:**
  - `step_o` <= s.
  - Entry e = table[s] is read before any same-cycle write, so a coincident write to s takes effect on the next visit.
  - If e != 0: `period_o` <= e, and the pluck counter loads `PLUCK_CYCLES`.
  - If e = 0 (rest): `period_o` holds, and the pluck counter is unchanged.
- **Pluck counter:**
  - `pluck_o` = (pluck counter != 0), registered.
  - The counter decrements to 0 each cycle when it is not being loaded.
  - A fire while the counter is nonzero reloads it. The pulse is stretched, never split, so `pluck_o` stays high continuously if `PLUCK_CYCLES` > `tempo_i` + 1.
- `tempo_i` and `length_i` are sampled live every cycle and are not latched. Raising `tempo_i` above the current tick mid-step just extends that step.
- **Reset values:** `pluck_o` = 0, `period_o` = 0, `step_o` = 0, `playing_o` = 0, tick = 0, pluck counter = 0, state IDLE, table all 0.
- **Reset mid-operation:** all of the above values apply asynchronously. Table contents are lost.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- **Start latency:** `run_i` is sampled high at edge k. At edge k, `playing_o` = 1, `step_o` = 0, `period_o` = table[0], and `pluck_o` = 1 if table[0] != 0.
- **Step period:** exactly `tempo_i` + 1 cycles between consecutive fires, so `pluck_o` rising edges are spaced `tempo_i` + 1 cycles apart when no rests occur.
- **Pluck width:** `PLUCK_CYCLES` cycles per fire, unless it is reloaded by the next fire.
- **Stop latency:** `run_i` is sampled low at edge k. At edge k, `playing_o` = 0, `pluck_o` = 0, and `step_o` = 0.
- **Write latency:** a write at edge k is visible to any fire at edge k+1 or later.

## Test plan
- **Reset values:** drive `rst_ni` low asynchronously mid-cycle while playing -> all outputs are 0 immediately, and the table reads back as rests (no pluck after restart until rewritten).
- **Basic playback:** write periods 10, 20, 30, 40 to steps 0-3; `length_i` = 3, `tempo_i` = 9, `run_i` = 1 ->
  - `period_o` sequence is 10, 20, 30, 40, 10.
  - `pluck_o` rising edges are 10 cycles apart, each 4 cycles wide.
  - `step_o` wraps from 3 to 0.
- **Rest:** step 1 = 0 in the basic-playback table -> no pluck at the step-1 fire, `period_o` stays 10 and `step_o` = 1, and the next pluck occurs 20 cycles after the step-0 pluck.
- **Stretched pulse:** `tempo_i` = 1, `PLUCK_CYCLES` = 4 -> `pluck_o` stays continuously high while playing nonzero steps.
- **Mid-play changes:**
  - Lower `length_i` from 7 to 2 while `step_o` = 5 -> the next fire is step 0.
  - Write step 0 = 99 in the same cycle as the step-0 fire -> that fire plays the old value, and the next lap plays 99.
- **Stop and restart:**
  - Drop `run_i` on the exact cycle tick = `tempo_i` -> no fire, and IDLE with `step_o` = 0.
  - Re-raise `run_i` -> a step-0 pluck on the sampling edge.
